// File: rtl/digit_serial_add_sub_if.sv
// Operand/result handshake bundle for digit_serial_add_sub.
// The master drives the operands and out_ready; the slave (the adder) returns the result.
interface digit_serial_add_sub_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, sub, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, sub, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/digit_serial_add_sub.sv
// Digit-serial adder/subtractor: one DIGIT-bit ripple slice per clock with a registered
// inter-digit carry, valid/ready on both sides, carry/borrow and signed overflow flags.
module digit_serial_add_sub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  digit_serial_add_sub_if.slave bus
);
  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);

  if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
    $error("digit_serial_add_sub: WIDTH must be a non-zero multiple of DIGIT");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_accept;
  logic             w_last;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic [DIGIT-1:0] w_da;
  logic [DIGIT-1:0] w_db;
  logic [DIGIT:0]   w_dsum;
  logic             w_cmsb;

  // Control: state register and next-state/handshake decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  assign w_last = (r_cnt == LAST_CNT);

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = rst_n;
        w_accept   = bus.in_valid & rst_n;
        if (w_accept) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Digit slice: operands shift right so the active digit is always the low DIGIT bits
  assign w_da   = r_a[DIGIT-1:0];
  assign w_db   = r_b[DIGIT-1:0];
  assign w_dsum = {1'b0, w_da} + {1'b0, w_db} + {{DIGIT{1'b0}}, r_carry};
  // On the last digit the slice MSB is the word MSB; its carry-in is recovered from a^b^s
  assign w_cmsb = w_da[DIGIT-1] ^ w_db[DIGIT-1] ^ w_dsum[DIGIT-1];

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a <= bus.a;
      r_b <= bus.sub ? ~bus.b : bus.b;
    end else if (r_state == S_RUN) begin
      r_a <= r_a >> DIGIT;
      r_b <= r_b >> DIGIT;
    end
  end

  // Result stage: sum digits enter at the top and walk down into place
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_carry <= bus.sub | bus.cin;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_sum   <= (r_sum >> DIGIT) | (WIDTH'(w_dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
      r_carry <= w_dsum[DIGIT];
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        r_cout <= w_dsum[DIGIT];
        r_ovf  <= w_cmsb ^ w_dsum[DIGIT];
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;
endmodule
